// File: rtl/ram8_seq_master_pkg.sv
// ---------------------------------------------------------------------------
// ram8_seq_pkg
// Shared definitions for the RAM8 sequencing master: command opcodes and the
// FSM state encoding used by the top level.
// ---------------------------------------------------------------------------
package ram8_seq_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Sequencer states; COPY is split into a read cycle and a write cycle
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_COPY_RD = 3'd2,
        ST_COPY_WR = 3'd3,
        ST_SUM     = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

endpackage

// File: rtl/ram8_seq_master_if.sv
// ---------------------------------------------------------------------------
// ram8_seq_master_if
// Bundles the command handshake, status outputs and RAM8 bus of the
// sequencing master.
//   master modport : the sequencer (drives cmd_ready/status/mem_addr/load/wdata)
//   slave  modport : the environment (drives cmd_* and mem_rdata)
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/src/dst/len/data/step  command fields
//   busy/done/err/result status and SUM result
//   mem_addr/mem_load/mem_wdata/mem_rdata  RAM8 port
// ---------------------------------------------------------------------------
interface ram8_seq_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_step;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_load;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data, cmd_step,
        input  mem_rdata,
        output cmd_ready, busy, done, err, result,
        output mem_addr, mem_load, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data, cmd_step,
        output mem_rdata,
        input  cmd_ready, busy, done, err, result,
        input  mem_addr, mem_load, mem_wdata
    );

endinterface

// File: rtl/ram8_seq_master_addr_gen.sv
// ---------------------------------------------------------------------------
// ram8_seq_addr_gen
// Word index counter plus the src+i / dst+i address adders for the current
// and the following word. Addresses wrap modulo 2**ADDR_W. o_last flags that
// the current index is the final word of the command.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_clear         restart the index at 0 (command accept)
//   i_adv           step to the next word
//   i_src/i_dst     latched start addresses
//   i_len           latched word count (1..2**ADDR_W while working)
//   o_src_cur/o_dst_cur  addresses of the current word
//   o_src_nxt/o_dst_nxt  addresses of the next word
//   o_last          current word is word len-1
// ---------------------------------------------------------------------------
module ram8_seq_addr_gen #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_adv,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W:0]   i_len,
    output logic [ADDR_W-1:0] o_src_cur,
    output logic [ADDR_W-1:0] o_dst_cur,
    output logic [ADDR_W-1:0] o_src_nxt,
    output logic [ADDR_W-1:0] o_dst_nxt,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;

    assign w_idx_nxt = r_idx + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_adv) begin
            r_idx <= w_idx_nxt;
        end
    end

    // Adders drop the carry, giving the wrap-around addressing for free
    assign o_src_cur = i_src + r_idx;
    assign o_dst_cur = i_dst + r_idx;
    assign o_src_nxt = i_src + w_idx_nxt;
    assign o_dst_nxt = i_dst + w_idx_nxt;

    // Index is one bit narrower than len, so widen it before comparing
    assign o_last = ({1'b0, r_idx} == (i_len - (ADDR_W+1)'(1)));

endmodule

// File: rtl/ram8_seq_master.sv
// ---------------------------------------------------------------------------
// ram8_seq_master
// Initiator for a RAM8-style memory. Takes one FILL / COPY / SUM command at a
// time over a valid/ready handshake, sequences the memory cycles and pulses
// done (with err for the reserved opcode) when finished.
// Ports:
//   clk    single clock, all state on posedge
//   rst_n  asynchronous active-low reset; aborts any command in flight
//   bus    ram8_seq_master_if.master: command fields, cmd_ready, busy, done,
//          err, result, and mem_addr/mem_load/mem_wdata/mem_rdata
// All bus outputs are registered; each state's outputs are loaded on the edge
// that enters that state, so addresses for the next word come from the
// address generator's "nxt" outputs.
// ---------------------------------------------------------------------------
module ram8_seq_master
    import ram8_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ram8_seq_master_if.master  bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_step;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_adv;
    logic [ADDR_W-1:0] w_src_cur;
    logic [ADDR_W-1:0] w_dst_cur;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic              w_last;

    assign w_accept = bus.cmd_valid && r_ready;

    // The index only moves after a word that is not the last one
    assign w_adv = !w_last && (r_state == ST_FILL    ||
                               r_state == ST_COPY_WR ||
                               r_state == ST_SUM);

    ram8_seq_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_adv     (w_adv),
        .i_src     (r_src),
        .i_dst     (r_dst),
        .i_len     (r_len),
        .o_src_cur (w_src_cur),
        .o_dst_cur (w_dst_cur),
        .o_src_nxt (w_src_nxt),
        .o_dst_nxt (w_dst_nxt),
        .o_last    (w_last)
    );

    // r_wdata doubles as the FILL value accumulator and the COPY hold
    // register; FIN always parks the memory port at address 0, no write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_step   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_addr   <= '0;
            r_load   <= 1'b0;
            r_wdata  <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src   <= bus.cmd_src;
                        r_dst   <= bus.cmd_dst;
                        r_len   <= bus.cmd_len;
                        r_step  <= bus.cmd_step;
                        r_acc   <= '0;
                        r_ready <= 1'b0;
                        if (bus.cmd_len == '0 || bus.cmd_op == OP_RSVD) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_err   <= (bus.cmd_op == OP_RSVD);
                        end else begin
                            r_busy <= 1'b1;
                            case (bus.cmd_op)
                                OP_FILL: begin
                                    r_state <= ST_FILL;
                                    r_addr  <= bus.cmd_dst;
                                    r_load  <= 1'b1;
                                    r_wdata <= bus.cmd_data;
                                end
                                OP_COPY: begin
                                    r_state <= ST_COPY_RD;
                                    r_addr  <= bus.cmd_src;
                                end
                                default: begin
                                    r_state <= ST_SUM;
                                    r_addr  <= bus.cmd_src;
                                end
                            endcase
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                ST_FILL: begin
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                        r_load  <= 1'b0;
                        r_wdata <= '0;
                    end else begin
                        r_addr  <= w_dst_nxt;
                        r_wdata <= r_wdata + r_step;
                    end
                end

                ST_COPY_RD: begin
                    r_state <= ST_COPY_WR;
                    r_wdata <= bus.mem_rdata;
                    r_addr  <= w_dst_cur;
                    r_load  <= 1'b1;
                end

                ST_COPY_WR: begin
                    r_load <= 1'b0;
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= '0;
                    end else begin
                        r_state <= ST_COPY_RD;
                        r_addr  <= w_src_nxt;
                    end
                end

                ST_SUM: begin
                    if (w_last) begin
                        r_result <= r_acc + bus.mem_rdata;
                        r_state  <= ST_FIN;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_addr   <= '0;
                    end else begin
                        r_acc  <= r_acc + bus.mem_rdata;
                        r_addr <= w_src_nxt;
                    end
                end

                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                    r_load  <= 1'b0;
                    r_wdata <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.result    = r_result;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_load  = r_load;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_ram8_seq_master.sv
// ---------------------------------------------------------------------------
// tb_ram8_seq_master
// Drives ram8_seq_master against a behavioural RAM8 and compares latency,
// err, result, write counts and memory contents with hand-computed values.
// ---------------------------------------------------------------------------
module tb_ram8_seq_master;
    import ram8_seq_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [3:0]  len;
        logic [15:0] data;
        logic [15:0] step;
        int          expLat;
        logic        expErr;
        logic [15:0] expResult;
        logic [2:0]  chkAddr;
        logic [15:0] chkVal;
        int          expLoads;
    } vec_t;

    localparam int NUM_VECS = 11;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem [0:7];
    int          loadCount;
    int          doneCount;
    int          checks;
    int          errors;
    vec_t        vecs [NUM_VECS];

    ram8_seq_master_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    ram8_seq_master #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM8: synchronous write, combinational read
    always @(posedge clk) begin
        if (bus.mem_load) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Count write cycles and done pulses so sequences can check them later
    always @(posedge clk) begin
        if (bus.mem_load) loadCount <= loadCount + 1;
        if (bus.done) doneCount <= doneCount + 1;
    end

    // Hard stop if something wedges the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one command, releases cmd_valid right after the accept edge
    // and counts accept-relative posedges until done shows up
    task automatic applyStimulus(input vec_t v, output int lat, output logic errSeen,
                                 output logic busySeen, output logic [15:0] resSeen,
                                 output int loads);
        int startLoads;
        @(negedge clk);
        bus.cmd_op    = v.op;
        bus.cmd_src   = v.src;
        bus.cmd_dst   = v.dst;
        bus.cmd_len   = v.len;
        bus.cmd_data  = v.data;
        bus.cmd_step  = v.step;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clk);
        startLoads = loadCount;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        errSeen  = bus.err;
        busySeen = bus.busy;
        resSeen  = bus.result;
        loads    = loadCount - startLoads;
    endtask

    // Main sequence: reset, vector table, reset-abort and back-to-back cases
    initial begin
        int          lat;
        int          loads;
        int          doneBefore;
        logic        errSeen;
        logic        busySeen;
        logic [15:0] resSeen;

        checks    = 0;
        errors    = 0;
        loadCount = 0;
        doneCount = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.cmd_step  = '0;

        //         op       src   dst   len    data      step     lat err res       chk  val      loads
        vecs[0]  = '{OP_FILL, 3'd0, 3'd0, 4'd8, 16'h0010, 16'h0001, 9, 1'b0, 16'h0000, 3'd7, 16'h0017, 8};
        vecs[1]  = '{OP_COPY, 3'd0, 3'd6, 4'd4, 16'h0000, 16'h0000, 9, 1'b0, 16'h0000, 3'd0, 16'h0012, 4};
        vecs[2]  = '{OP_SUM,  3'd0, 3'd0, 4'd8, 16'h0000, 16'h0000, 9, 1'b0, 16'h0094, 3'd6, 16'h0010, 0};
        vecs[3]  = '{OP_SUM,  3'd6, 3'd0, 4'd3, 16'h0000, 16'h0000, 4, 1'b0, 16'h0033, 3'd1, 16'h0013, 0};
        vecs[4]  = '{OP_FILL, 3'd0, 3'd0, 4'd0, 16'h5555, 16'h0001, 1, 1'b0, 16'h0033, 3'd0, 16'h0012, 0};
        vecs[5]  = '{OP_RSVD, 3'd0, 3'd0, 4'd5, 16'h5555, 16'h0001, 1, 1'b1, 16'h0033, 3'd0, 16'h0012, 0};
        vecs[6]  = '{OP_FILL, 3'd0, 3'd6, 4'd4, 16'hFFFE, 16'h0001, 5, 1'b0, 16'h0033, 3'd1, 16'h0001, 4};
        vecs[7]  = '{OP_FILL, 3'd0, 3'd0, 4'd8, 16'hFFFF, 16'h0000, 9, 1'b0, 16'h0033, 3'd3, 16'hFFFF, 8};
        vecs[8]  = '{OP_SUM,  3'd0, 3'd0, 4'd8, 16'h0000, 16'h0000, 9, 1'b0, 16'hFFF8, 3'd0, 16'hFFFF, 0};
        vecs[9]  = '{OP_FILL, 3'd0, 3'd2, 4'd1, 16'hABCD, 16'h0005, 2, 1'b0, 16'hFFF8, 3'd2, 16'hABCD, 1};
        vecs[10] = '{OP_COPY, 3'd2, 3'd5, 4'd1, 16'h0000, 16'h0000, 3, 1'b0, 16'hFFF8, 3'd5, 16'hABCD, 1};

        // Reset state: every output low while rst_n is held
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cmd_ready", bus.cmd_ready, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset err", bus.err, 0);
        checkOutput("reset result", bus.result, 0);
        checkOutput("reset mem_addr", bus.mem_addr, 0);
        checkOutput("reset mem_load", bus.mem_load, 0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset cmd_ready", bus.cmd_ready, 1);

        // Vector table
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], lat, errSeen, busySeen, resSeen, loads);
            checkOutput($sformatf("v%0d latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("v%0d err", i), errSeen, vecs[i].expErr);
            checkOutput($sformatf("v%0d busy at done", i), busySeen, 0);
            checkOutput($sformatf("v%0d result", i), resSeen, vecs[i].expResult);
            checkOutput($sformatf("v%0d write count", i), loads, vecs[i].expLoads);
            checkOutput($sformatf("v%0d mem[%0d]", i, vecs[i].chkAddr),
                        mem[vecs[i].chkAddr], vecs[i].chkVal);
        end
        checkOutput("copy wrap mem[6]", mem[6], 16'hFFFF);
        checkOutput("copy 1-word mem[5]", mem[5], 16'hABCD);

        // Reset in the middle of a FILL: words 0..1 land, word 2 never does
        @(negedge clk);
        bus.cmd_op    = OP_FILL;
        bus.cmd_dst   = 3'd0;
        bus.cmd_len   = 4'd8;
        bus.cmd_data  = 16'h0100;
        bus.cmd_step  = 16'h0001;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clk);
        doneBefore = doneCount;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mid-fill word2 addr", bus.mem_addr, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", bus.busy, 0);
        checkOutput("abort mem_load", bus.mem_load, 0);
        checkOutput("abort mem_addr", bus.mem_addr, 0);
        checkOutput("abort mem_wdata", bus.mem_wdata, 0);
        checkOutput("abort cmd_ready", bus.cmd_ready, 0);
        checkOutput("abort done", bus.done, 0);
        checkOutput("abort result", bus.result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort post-reset cmd_ready", bus.cmd_ready, 1);
        checkOutput("abort no done pulse", doneCount - doneBefore, 0);
        checkOutput("abort mem[0]", mem[0], 16'h0100);
        checkOutput("abort mem[1]", mem[1], 16'h0101);
        checkOutput("abort mem[2]", mem[2], 16'hABCD);

        // Back-to-back FILLs with cmd_valid held; fields scrambled while busy
        @(negedge clk);
        bus.cmd_op    = OP_FILL;
        bus.cmd_dst   = 3'd0;
        bus.cmd_src   = 3'd0;
        bus.cmd_len   = 4'd2;
        bus.cmd_data  = 16'h1111;
        bus.cmd_step  = 16'h1111;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_op   = OP_COPY;
        bus.cmd_dst  = 3'd7;
        bus.cmd_src  = 3'd3;
        bus.cmd_len  = 4'd8;
        bus.cmd_data = 16'hDEAD;
        bus.cmd_step = 16'hBEEF;
        @(posedge clk);
        #1;
        checkOutput("b2b first busy", bus.busy, 1);
        bus.cmd_op   = OP_FILL;
        bus.cmd_dst  = 3'd4;
        bus.cmd_src  = 3'd0;
        bus.cmd_len  = 4'd2;
        bus.cmd_data = 16'h2222;
        bus.cmd_step = 16'h0001;
        @(posedge clk);
        #1;
        checkOutput("b2b first done", bus.done, 1);
        @(posedge clk);
        #1;
        checkOutput("b2b idle cmd_ready", bus.cmd_ready, 1);
        checkOutput("b2b idle done low", bus.done, 0);
        @(posedge clk);
        #1;
        checkOutput("b2b second accepted busy", bus.busy, 1);
        checkOutput("b2b second accepted ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("b2b second latency", lat, 3);
        checkOutput("b2b mem[0]", mem[0], 16'h1111);
        checkOutput("b2b mem[1]", mem[1], 16'h2222);
        checkOutput("b2b mem[4]", mem[4], 16'h2222);
        checkOutput("b2b mem[5]", mem[5], 16'h2223);
        checkOutput("b2b mem[7] untouched", mem[7], 16'hFFFF);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
